uart_axi_probe: RTL

Byte-stream debug probe: a host issues framed commands over a UART byte channel (valid/ready). The probe drives a parametrised GPO bank, samples a GPI bank and acts as a single-beat AXI4-Lite-style master with full-width data, response reporting and optional address auto-increment. It is the parametrised successor to the 8-bit probe, with multi-byte payloads, an explicit FSM, AXI handshakes that wait for responses, and a status/NAK byte per transaction.

---
 rtl/uart_axi_probe_pkg.sv | 37 +++
 rtl/uart_axi_probe_if.sv | 52 +++++
 rtl/uart_axi_probe_bytebuf.sv | 58 +++++
 rtl/uart_axi_probe.sv | 260 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_axi_probe_pkg.sv
// Shared opcodes, FSM state encoding and response-byte helpers for the UART/AXI debug probe.
package uart_axi_probe_pkg;

    localparam logic [7:0] OP_GPI_RD  = 8'h01;
    localparam logic [7:0] OP_GPO_RD  = 8'h02;
    localparam logic [7:0] OP_GPO_WR  = 8'h03;
    localparam logic [7:0] OP_ADDR_WR = 8'h04;
    localparam logic [7:0] OP_ADDR_RD = 8'h05;
    localparam logic [7:0] OP_CTRL_WR = 8'h06;
    localparam logic [7:0] OP_AXI_RD  = 8'h07;
    localparam logic [7:0] OP_AXI_WR  = 8'h08;

    localparam logic [7:0] STATUS_BASE = 8'h04;
    localparam logic [7:0] NAK         = 8'hEE;

    typedef enum logic [2:0] {
        IDLE,
        RX_PLD,
        AXI_AR,
        AXI_R,
        AXI_AW,
        AXI_B,
        TX
    } state_t;

    function automatic logic [7:0] status_byte(input logic [1:0] resp);
        return STATUS_BASE | {6'b0, resp};
    endfunction

    function automatic int unsigned max3(input int unsigned a, input int unsigned b,
                                         input int unsigned c);
        int unsigned m;
        m = (a > b) ? a : b;
        return (m > c) ? m : c;
    endfunction

endpackage

// File: rtl/uart_axi_probe_if.sv
// Host byte channels plus the single-beat AXI4-Lite master bus of the probe.
interface uart_axi_probe_if #(
    parameter int unsigned AXI_DW = 32
);
    logic                  rx_valid;
    logic [7:0]            rx_data;
    logic                  rx_ready;
    logic                  tx_valid;
    logic [7:0]            tx_data;
    logic                  tx_ready;

    logic [31:0]           m_axi_araddr;
    logic [2:0]            m_axi_arsize;
    logic                  m_axi_arvalid;
    logic                  m_axi_arready;
    logic [AXI_DW-1:0]     m_axi_rdata;
    logic [1:0]            m_axi_rresp;
    logic                  m_axi_rvalid;
    logic                  m_axi_rready;
    logic [31:0]           m_axi_awaddr;
    logic [2:0]            m_axi_awsize;
    logic                  m_axi_awvalid;
    logic                  m_axi_awready;
    logic [AXI_DW-1:0]     m_axi_wdata;
    logic [AXI_DW/8-1:0]   m_axi_wstrb;
    logic                  m_axi_wvalid;
    logic                  m_axi_wready;
    logic [1:0]            m_axi_bresp;
    logic                  m_axi_bvalid;
    logic                  m_axi_bready;

    modport master (
        input  rx_valid, rx_data, output rx_ready,
        output tx_valid, tx_data, input  tx_ready,
        output m_axi_araddr, m_axi_arsize, m_axi_arvalid, input m_axi_arready,
        input  m_axi_rdata, m_axi_rresp, m_axi_rvalid, output m_axi_rready,
        output m_axi_awaddr, m_axi_awsize, m_axi_awvalid, input m_axi_awready,
        output m_axi_wdata, m_axi_wstrb, m_axi_wvalid, input m_axi_wready,
        input  m_axi_bresp, m_axi_bvalid, output m_axi_bready
    );

    modport slave (
        output rx_valid, rx_data, input  rx_ready,
        input  tx_valid, tx_data, output tx_ready,
        input  m_axi_araddr, m_axi_arsize, m_axi_arvalid, output m_axi_arready,
        output m_axi_rdata, m_axi_rresp, m_axi_rvalid, input m_axi_rready,
        input  m_axi_awaddr, m_axi_awsize, m_axi_awvalid, output m_axi_awready,
        input  m_axi_wdata, m_axi_wstrb, m_axi_wvalid, output m_axi_wready,
        output m_axi_bresp, m_axi_bvalid, input m_axi_bready
    );

endinterface

// File: rtl/uart_axi_probe_bytebuf.sv
// Byte-indexed buffer with a byte counter: assembles rx payloads and serialises tx responses LSB first.
module uart_axi_probe_bytebuf #(
    parameter int unsigned NBYTES = 4,
    parameter int unsigned CW     = $clog2(NBYTES + 1)
) (
    input  logic                clk,
    input  logic                m_aresetn,
    input  logic                load,
    input  logic [NBYTES*8-1:0] load_data,
    input  logic [CW-1:0]       load_len,
    input  logic                push,
    input  logic [7:0]          push_byte,
    input  logic                shift,
    output logic [7:0]          byte_out,
    output logic [NBYTES*8-1:0] merged,
    output logic                last
);

    logic [NBYTES*8-1:0] data_q;
    logic [CW-1:0]       cnt;
    logic [CW-1:0]       len;

    // merged is the buffer with the incoming byte already in place, so a
    // consumer can commit the whole field on the cycle the last byte lands.
    always_comb begin
        merged = data_q;
        for (int unsigned i = 0; i < NBYTES; i++) begin
            if (cnt == CW'(i)) merged[i*8 +: 8] = push_byte;
        end
    end

    always_comb begin
        byte_out = '0;
        for (int unsigned i = 0; i < NBYTES; i++) begin
            if (cnt == CW'(i)) byte_out = data_q[i*8 +: 8];
        end
    end

    assign last = (cnt == len - CW'(1));

    always_ff @(posedge clk or negedge m_aresetn) begin
        if (!m_aresetn) begin
            data_q <= '0;
            cnt    <= '0;
            len    <= '0;
        end else if (load) begin
            data_q <= load_data;
            cnt    <= '0;
            len    <= load_len;
        end else if (push) begin
            data_q <= merged;
            cnt    <= cnt + CW'(1);
        end else if (shift) begin
            cnt    <= cnt + CW'(1);
        end
    end

endmodule

// File: rtl/uart_axi_probe.sv
// Byte-stream debug probe: decodes host commands, drives GPO, samples GPI and masters single AXI beats.
module uart_axi_probe
    import uart_axi_probe_pkg::*;
#(
    parameter int unsigned       GPIO_W        = 32,
    parameter int unsigned       AXI_DW        = 32,
    parameter logic [GPIO_W-1:0] GPO_ON_RESET  = '0,
    parameter logic [31:0]       ADDR_ON_RESET = 32'h0
) (
    input  logic               clk,
    input  logic               m_aresetn,
    output logic [GPIO_W-1:0]  gpo,
    input  logic [GPIO_W-1:0]  gpi,
    uart_axi_probe_if.master   bus
);

    localparam int unsigned GB     = GPIO_W / 8;
    localparam int unsigned NB     = AXI_DW / 8;
    localparam int unsigned NBYTES = max3(GB, NB, 4);
    localparam int unsigned CW     = $clog2(NBYTES + 1);
    localparam int unsigned BW     = NBYTES * 8;
    localparam logic [2:0]  AXSIZE = 3'($clog2(NB));

    state_t              state;
    logic [7:0]          cmd;
    logic [GPIO_W-1:0]   gpo_q;
    logic [31:0]         addr;
    logic                ae;
    logic                rx_ready_q;
    logic                tx_valid_q;
    logic                arvalid_q;
    logic                rready_q;
    logic                awvalid_q;
    logic                wvalid_q;
    logic                bready_q;
    logic [AXI_DW-1:0]   wdata_q;
    logic [1:0]          status_q;
    logic                status_pend;

    logic                rx_hs, tx_hs, r_hs, b_hs;
    logic                buf_load, buf_push, buf_shift, buf_last;
    logic [BW-1:0]       buf_load_data, buf_merged;
    logic [CW-1:0]       buf_load_len;
    logic [7:0]          buf_byte;

    assign rx_hs = bus.rx_valid && rx_ready_q;
    assign tx_hs = tx_valid_q && bus.tx_ready;
    assign r_hs  = rready_q && bus.m_axi_rvalid;
    assign b_hs  = bready_q && bus.m_axi_bvalid;

    assign gpo               = gpo_q;
    assign bus.rx_ready      = rx_ready_q;
    assign bus.tx_valid      = tx_valid_q;
    assign bus.tx_data       = buf_byte;
    assign bus.m_axi_araddr  = addr;
    assign bus.m_axi_arsize  = AXSIZE;
    assign bus.m_axi_arvalid = arvalid_q;
    assign bus.m_axi_rready  = rready_q;
    assign bus.m_axi_awaddr  = addr;
    assign bus.m_axi_awsize  = AXSIZE;
    assign bus.m_axi_awvalid = awvalid_q;
    assign bus.m_axi_wdata   = wdata_q;
    assign bus.m_axi_wstrb   = '1;
    assign bus.m_axi_wvalid  = wvalid_q;
    assign bus.m_axi_bready  = bready_q;

    // Buffer control: snapshots and response data are loaded on the very
    // handshake that moves the FSM into TX or RX_PLD.
    always_comb begin
        buf_load      = 1'b0;
        buf_load_data = '0;
        buf_load_len  = '0;
        buf_push      = 1'b0;
        buf_shift     = 1'b0;
        case (state)
            IDLE: begin
                if (rx_hs) begin
                    buf_load = 1'b1;
                    case (bus.rx_data)
                        OP_GPI_RD: begin
                            buf_load_data[GPIO_W-1:0] = gpi;
                            buf_load_len = CW'(GB);
                        end
                        OP_GPO_RD: begin
                            buf_load_data[GPIO_W-1:0] = gpo_q;
                            buf_load_len = CW'(GB);
                        end
                        OP_GPO_WR:  buf_load_len = CW'(GB);
                        OP_ADDR_WR: buf_load_len = CW'(4);
                        OP_ADDR_RD: begin
                            buf_load_data[31:0] = addr;
                            buf_load_len = CW'(4);
                        end
                        OP_CTRL_WR: buf_load_len = CW'(1);
                        OP_AXI_RD:  buf_load = 1'b0;
                        OP_AXI_WR:  buf_load_len = CW'(NB);
                        default: begin
                            buf_load_data[7:0] = NAK;
                            buf_load_len = CW'(1);
                        end
                    endcase
                end
            end
            RX_PLD: buf_push = rx_hs;
            AXI_R: begin
                if (r_hs) begin
                    buf_load = 1'b1;
                    buf_load_data[AXI_DW-1:0] = bus.m_axi_rdata;
                    buf_load_len = CW'(NB);
                end
            end
            AXI_B: begin
                if (b_hs) begin
                    buf_load = 1'b1;
                    buf_load_data[7:0] = status_byte(bus.m_axi_bresp);
                    buf_load_len = CW'(1);
                end
            end
            TX: begin
                if (tx_hs) begin
                    if (buf_last) begin
                        // AXI_RD: data bytes drained, follow with the status byte
                        if (status_pend) begin
                            buf_load = 1'b1;
                            buf_load_data[7:0] = status_byte(status_q);
                            buf_load_len = CW'(1);
                        end
                    end else begin
                        buf_shift = 1'b1;
                    end
                end
            end
            default: ;
        endcase
    end

    uart_axi_probe_bytebuf #(
        .NBYTES (NBYTES),
        .CW     (CW)
    ) u_bytebuf (
        .clk       (clk),
        .m_aresetn (m_aresetn),
        .load      (buf_load),
        .load_data (buf_load_data),
        .load_len  (buf_load_len),
        .push      (buf_push),
        .push_byte (bus.rx_data),
        .shift     (buf_shift),
        .byte_out  (buf_byte),
        .merged    (buf_merged),
        .last      (buf_last)
    );

    always_ff @(posedge clk or negedge m_aresetn) begin
        if (!m_aresetn) begin
            state       <= IDLE;
            cmd         <= '0;
            gpo_q       <= GPO_ON_RESET;
            addr        <= ADDR_ON_RESET;
            ae          <= 1'b0;
            rx_ready_q  <= 1'b0;
            tx_valid_q  <= 1'b0;
            arvalid_q   <= 1'b0;
            rready_q    <= 1'b0;
            awvalid_q   <= 1'b0;
            wvalid_q    <= 1'b0;
            bready_q    <= 1'b0;
            wdata_q     <= '0;
            status_q    <= '0;
            status_pend <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    rx_ready_q <= 1'b1;
                    if (rx_hs) begin
                        cmd <= bus.rx_data;
                        case (bus.rx_data)
                            OP_GPO_WR, OP_ADDR_WR, OP_CTRL_WR, OP_AXI_WR: state <= RX_PLD;
                            OP_AXI_RD: begin
                                state      <= AXI_AR;
                                arvalid_q  <= 1'b1;
                                rx_ready_q <= 1'b0;
                            end
                            default: begin
                                state       <= TX;
                                tx_valid_q  <= 1'b1;
                                rx_ready_q  <= 1'b0;
                                status_pend <= 1'b0;
                            end
                        endcase
                    end
                end
                RX_PLD: begin
                    if (rx_hs && buf_last) begin
                        state <= IDLE;
                        case (cmd)
                            OP_GPO_WR:  gpo_q <= buf_merged[GPIO_W-1:0];
                            OP_ADDR_WR: addr  <= buf_merged[31:0];
                            OP_AXI_WR: begin
                                wdata_q    <= buf_merged[AXI_DW-1:0];
                                awvalid_q  <= 1'b1;
                                wvalid_q   <= 1'b1;
                                rx_ready_q <= 1'b0;
                                state      <= AXI_AW;
                            end
                            default:    ae <= bus.rx_data[0];
                        endcase
                    end
                end
                AXI_AR: begin
                    if (bus.m_axi_arready) begin
                        arvalid_q <= 1'b0;
                        rready_q  <= 1'b1;
                        state     <= AXI_R;
                    end
                end
                AXI_R: begin
                    if (r_hs) begin
                        rready_q    <= 1'b0;
                        status_q    <= bus.m_axi_rresp;
                        status_pend <= 1'b1;
                        tx_valid_q  <= 1'b1;
                        state       <= TX;
                        if (ae) addr <= addr + 32'(NB);
                    end
                end
                AXI_AW: begin
                    if (bus.m_axi_awready) awvalid_q <= 1'b0;
                    if (bus.m_axi_wready)  wvalid_q  <= 1'b0;
                    if ((!awvalid_q || bus.m_axi_awready) && (!wvalid_q || bus.m_axi_wready)) begin
                        bready_q <= 1'b1;
                        state    <= AXI_B;
                    end
                end
                AXI_B: begin
                    if (b_hs) begin
                        bready_q    <= 1'b0;
                        status_pend <= 1'b0;
                        tx_valid_q  <= 1'b1;
                        state       <= TX;
                        if (ae) addr <= addr + 32'(NB);
                    end
                end
                TX: begin
                    if (tx_hs && buf_last) begin
                        if (status_pend) begin
                            status_pend <= 1'b0;
                        end else begin
                            tx_valid_q <= 1'b0;
                            rx_ready_q <= 1'b1;
                            state      <= IDLE;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
